// File: rtl/adder_arbiter_pkg.sv
// Shared definitions for the adder_arbiter block.
// Holds the default operand width, the default requester count and the
// function that derives the requester-index width from the requester count.
package adder_arbiter_pkg;

    localparam int DEFAULT_WIDTH = 32'sd16;
    localparam int DEFAULT_N_REQ = 32'sd4;

    // Smallest w >= 1 with 2**w >= n (clog2, but never zero so an index port
    // always has at least one bit).
    function automatic int id_width(input int n);
        int w;
        w = 32'sd1;
        while ((32'sd1 << w) < n) begin
            w = w + 32'sd1;
        end
        return w;
    endfunction

endpackage

// File: rtl/adder_arbiter_rr.sv
// rr_arbiter: round-robin arbiter with an owned rotation pointer.
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   valid       per-requester request vector
//   enable      arbitration allowed this cycle (low -> no grant, pointer holds)
//   grant       one-hot grant, all zero when nothing is granted
//   grant_idx   index of the granted requester (meaningful when grant_any)
//   grant_any   a grant is issued this cycle
module rr_arbiter
    import adder_arbiter_pkg::*;
#(
    parameter int N_REQ = DEFAULT_N_REQ,
    parameter int ID_W  = id_width(N_REQ)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] valid,
    input  logic             enable,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  grant_idx,
    output logic             grant_any
);

    logic [ID_W-1:0] ptr_r;
    logic [ID_W-1:0] cand_s;
    logic [ID_W-1:0] pick_s;
    logic            found_s;

    // Scan upward from the pointer with wrap; the first valid requester wins.
    always_comb begin
        pick_s  = ptr_r;
        found_s = 1'b0;
        cand_s  = ptr_r;
        for (int off = 0; off < N_REQ; off++) begin
            cand_s = ID_W'((int'(ptr_r) + off) % N_REQ);
            if (!found_s && valid[cand_s]) begin
                found_s = 1'b1;
                pick_s  = cand_s;
            end else begin
                found_s = found_s;
            end
        end
    end

    // Expand the winner into a one-hot grant, suppressed when not enabled.
    always_comb begin
        grant     = '0;
        grant_any = enable & found_s;
        grant_idx = pick_s;
        if (grant_any) begin
            grant[pick_s] = 1'b1;
        end else begin
            grant = '0;
        end
    end

    // Pointer moves to one past the winner after a grant, otherwise holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_r <= '0;
        end else if (grant_any) begin
            ptr_r <= (pick_s == ID_W'(N_REQ - 1)) ? '0 : pick_s + ID_W'(1'b1);
        end else begin
            ptr_r <= ptr_r;
        end
    end

endmodule

// File: rtl/adder_arbiter.sv
// adder_arbiter: N_REQ requesters share one WIDTH-bit adder through a
// round-robin arbiter and a 2-stage pipeline (S1 operands, S2 result).
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   req_valid   per-requester operand-pair valid
//   req_a/req_b packed operands, requester i in bits [i*WIDTH +: WIDTH]
//   req_ready   one-hot grant (combinational)
//   res_valid   result valid; res_ready downstream accept
//   res_sum     A+B modulo 2**WIDTH; res_carry carry-out; res_id requester
module adder_arbiter
    import adder_arbiter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int N_REQ = DEFAULT_N_REQ,
    parameter int ID_W  = id_width(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*WIDTH-1:0] req_a,
    input  logic [N_REQ*WIDTH-1:0] req_b,
    output logic [N_REQ-1:0]       req_ready,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [WIDTH-1:0]       res_sum,
    output logic                   res_carry,
    output logic [ID_W-1:0]        res_id
);

    logic             stall_s;
    logic             arb_en_s;
    logic [N_REQ-1:0] grant_s;
    logic [ID_W-1:0]  grant_idx_s;
    logic             grant_any_s;
    logic [WIDTH-1:0] sel_a_s;
    logic [WIDTH-1:0] sel_b_s;
    logic [WIDTH:0]   sum_s;

    logic             s1_valid_r;
    logic [WIDTH-1:0] s1_a_r;
    logic [WIDTH-1:0] s1_b_r;
    logic [ID_W-1:0]  s1_id_r;

    // A held result freezes the whole pipe. Reset also gates arbitration so
    // no grant is shown while rst_n is low.
    assign stall_s   = res_valid & ~res_ready;
    assign arb_en_s  = rst_n & ~stall_s;
    assign req_ready = grant_s;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid     (req_valid),
        .enable    (arb_en_s),
        .grant     (grant_s),
        .grant_idx (grant_idx_s),
        .grant_any (grant_any_s)
    );

    // One-hot AND-OR mux picks the granted requester's operands.
    always_comb begin
        sel_a_s = '0;
        sel_b_s = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_s[i]) begin
                sel_a_s = sel_a_s | req_a[i*WIDTH +: WIDTH];
                sel_b_s = sel_b_s | req_b[i*WIDTH +: WIDTH];
            end else begin
                sel_a_s = sel_a_s;
                sel_b_s = sel_b_s;
            end
        end
    end

    // The single shared adder; the extra top bit is the carry-out.
    assign sum_s = {1'b0, s1_a_r} + {1'b0, s1_b_r};

    // Stage 1: capture the granted pair, or a bubble when nothing was granted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_r <= 1'b0;
            s1_a_r     <= '0;
            s1_b_r     <= '0;
            s1_id_r    <= '0;
        end else if (!stall_s) begin
            s1_valid_r <= grant_any_s;
            s1_a_r     <= sel_a_s;
            s1_b_r     <= sel_b_s;
            s1_id_r    <= grant_idx_s;
        end else begin
            s1_valid_r <= s1_valid_r;
            s1_a_r     <= s1_a_r;
            s1_b_r     <= s1_b_r;
            s1_id_r    <= s1_id_r;
        end
    end

    // Stage 2: register the sum; holds unchanged while downstream stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid <= 1'b0;
            res_sum   <= '0;
            res_carry <= 1'b0;
            res_id    <= '0;
        end else if (!stall_s) begin
            res_valid <= s1_valid_r;
            res_sum   <= sum_s[WIDTH-1:0];
            res_carry <= sum_s[WIDTH];
            res_id    <= s1_id_r;
        end else begin
            res_valid <= res_valid;
            res_sum   <= res_sum;
            res_carry <= res_carry;
            res_id    <= res_id;
        end
    end

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed self-checking bench for adder_arbiter (WIDTH=16, N_REQ=4).
module tb_adder_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [63:0] req_a;
    logic [63:0] req_b;
    logic [3:0]  req_ready;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_sum;
    logic        res_carry;
    logic [1:0]  res_id;

    int checks;
    int failures;

    adder_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_sum   (res_sum),
        .res_carry (res_carry),
        .res_id    (res_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Operand pattern used for the multi-requester streams.
    function automatic logic [15:0] pat_a(input int i);
        return 16'h0100 * 16'(i + 1);
    endfunction
    function automatic logic [15:0] pat_b(input int i);
        return 16'(i);
    endfunction

    task automatic check_result(input string tag, input int id);
        check({tag, "_valid"}, {31'd0, res_valid}, 32'd1);
        check({tag, "_id"}, {30'd0, res_id}, 32'(id));
        check({tag, "_sum"}, {16'd0, res_sum}, {16'd0, pat_a(id) + pat_b(id)});
        check({tag, "_carry"}, {31'd0, res_carry}, 32'd0);
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        res_ready = 1'b1;
        req_valid = 4'b1111;
        req_a     = 64'd0;
        req_b     = 64'd0;

        // Reset state with every requester asking.
        tick();
        tick();
        check("rst_ready", {28'd0, req_ready}, 32'h0);
        check("rst_res_valid", {31'd0, res_valid}, 32'd0);
        check("rst_sum", {16'd0, res_sum}, 32'd0);
        check("rst_carry", {31'd0, res_carry}, 32'd0);
        check("rst_id", {30'd0, res_id}, 32'd0);

        // Release: requester 0 is granted first; withdraw before the edge.
        rst_n = 1'b1;
        #1;
        check("first_grant", {28'd0, req_ready}, 32'b0001);
        req_valid = 4'b0000;
        #1;
        check("idle_ready", {28'd0, req_ready}, 32'b0000);
        tick();

        // Single request from requester 1.
        req_valid = 4'b0010;
        req_a[16 +: 16] = 16'h1234;
        req_b[16 +: 16] = 16'h0001;
        #1;
        check("single_ready", {28'd0, req_ready}, 32'b0010);
        tick();
        req_valid = 4'b0000;
        check("single_lat1", {31'd0, res_valid}, 32'd0);
        tick();
        check("single_valid", {31'd0, res_valid}, 32'd1);
        check("single_sum", {16'd0, res_sum}, 32'h1235);
        check("single_carry", {31'd0, res_carry}, 32'd0);
        check("single_id", {30'd0, res_id}, 32'd1);
        tick();
        check("single_bubble", {31'd0, res_valid}, 32'd0);

        // Overflow from requester 3.
        req_valid = 4'b1000;
        req_a[48 +: 16] = 16'hFFFF;
        req_b[48 +: 16] = 16'h0002;
        #1;
        check("ovf_ready", {28'd0, req_ready}, 32'b1000);
        tick();
        req_valid = 4'b0000;
        tick();
        check("ovf_valid", {31'd0, res_valid}, 32'd1);
        check("ovf_sum", {16'd0, res_sum}, 32'h0001);
        check("ovf_carry", {31'd0, res_carry}, 32'd1);
        check("ovf_id", {30'd0, res_id}, 32'd3);
        tick();

        // Fairness: all four asking for 8 grants, pointer starts at 0.
        for (int i = 0; i < 4; i++) begin
            req_a[i*16 +: 16] = pat_a(i);
            req_b[i*16 +: 16] = pat_b(i);
        end
        req_valid = 4'b1111;
        for (int c = 0; c < 9; c++) begin
            #1;
            if (c < 8) begin
                check("rr_grant", {28'd0, req_ready}, 32'(4'b0001 << (c % 4)));
            end else begin
                req_valid = 4'b0000;
            end
            tick();
            if (c >= 1) begin
                check_result("rr_res", (c - 1) % 4);
            end
        end
        tick();
        check("rr_drain", {31'd0, res_valid}, 32'd0);

        // Backpressure: g0 in S2, g1 in S1, pointer at 2, then stall 3 cycles.
        req_valid = 4'b1111;
        tick();
        tick();
        res_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
            #1;
            check("bp_ready", {28'd0, req_ready}, 32'b0000);
            check_result("bp_hold", 0);
            tick();
        end
        res_ready = 1'b1;
        #1;
        check("bp_resume_grant", {28'd0, req_ready}, 32'b0100);
        tick();
        check_result("bp_res1", 1);
        check("bp_grant3", {28'd0, req_ready}, 32'b1000);
        tick();
        check_result("bp_res2", 2);
        req_valid = 4'b0000;
        tick();
        check_result("bp_res3", 3);
        tick();
        check("bp_drain", {31'd0, res_valid}, 32'd0);

        // Reset mid-flight with both stages valid.
        req_valid = 4'b1111;
        tick();
        tick();
        check("mid_pre_valid", {31'd0, res_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", {31'd0, res_valid}, 32'd0);
        check("mid_rst_ready", {28'd0, req_ready}, 32'b0000);
        req_valid = 4'b0000;
        tick();
        rst_n = 1'b1;
        tick();
        check("mid_post1", {31'd0, res_valid}, 32'd0);
        tick();
        check("mid_post2", {31'd0, res_valid}, 32'd0);
        req_valid = 4'b0100;
        #1;
        check("mid_ptr_zero", {28'd0, req_ready}, 32'b0100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
